riscv_noicache_pfq: RTL
=======================

# riscv_noicache_pfq

Instruction-fetch front end for cores built without an instruction cache. It issues fetch requests to the BIU and keeps up to DEPTH requests outstanding or buffered. Returned parcels are held in a DEPTH-entry prefetch queue that the IF stage drains with an explicit read strobe. It sits between the IF stage and the instruction BIU, in the position normally filled by the icache, and adds credit-based flow control and flush-safe discard of stale responses.

## Interface
- XLEN, 32, data/PC width (32 or 64)
- ALEN, XLEN, physical address width (≤ XLEN)
- PARCEL_SIZE, 16, parcel width in bits
- HAS_RVC, 0, nonzero means 16-bit alignment is legal
- DEPTH, 4, combined capacity of outstanding requests plus queue entries; power of 2, ≥ 2
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- if_nxt_pc_i  in  XLEN  next fetch address
- if_req_i  in  1  fetch request
- if_ack_o  out  1  fetch address accepted by the BIU
- if_prot_i  in  biu_prot_t  protection attributes for the fetch
- if_flush_i  in  1  flush: drop the queue and all in-flight responses
- if_parcel_rd_i  in  1  IF stage consumes the queue head
- if_parcel_pc_o  out  XLEN  address of the head parcel
- if_parcel_o  out  XLEN  data of the head parcel
- if_parcel_valid_o  out  XLEN/PARCEL_SIZE  per-parcel valid mask for the head entry
- if_parcel_misaligned_o  out  1  head PC misaligned
- if_parcel_error_o  out  1  head entry carries a bus error
- dcflush_rdy_i  in  1  data-cache flush complete; fetching is allowed
- biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_adri_o[ALEN], biu_adro_i[ALEN], biu_size_o, biu_type_o, biu_lock_o, biu_we_o, biu_prot_o, biu_d_o[XLEN], biu_q_i[XLEN], biu_ack_i, biu_err_i: standard BIU request/response channel

## Operation
- Counters:
  - `inflight` and `count` are each $clog2(DEPTH)+1 bits wide.
  - occ = inflight + count; occ never exceeds DEPTH.
- Issue:
  - biu_stb_o = dcflush_rdy_i & ~if_flush_i & if_req_i & (occ < DEPTH).
  - if_ack_o = biu_stb_o & biu_stb_ack_i.
  - biu_adri_o = if_nxt_pc_i[ALEN-1:0].
  - biu_size_o = DWORD when XLEN=64, otherwise WORD.
  - biu_type_o = SINGLE when if_nxt_pc_i is not XLEN-aligned, otherwise INCR.
  - biu_prot_o = if_prot_i.
  - biu_lock_o, biu_we_o and biu_d_o are tied to 0.
- inflight update:
  - Increments on if_ack_o.
  - Decrements on rsp = biu_ack_i | biu_err_i.
  - Both in the same cycle: unchanged.
  - rsp while inflight=0 is ignored; the counter stays at 0.
- discard update:
  - On if_flush_i, discard loads inflight, minus 1 if rsp is asserted in that cycle.
  - Otherwise, discard decrements on rsp while discard ≠ 0.
- Queue push:
  - Push = rsp & (discard=0) & ~if_flush_i.
  - The entry stores {biu_adro_i zero-extended to XLEN, biu_q_i, biu_err_i}.
- Queue pop:
  - Pop = if_parcel_rd_i & (count ≠ 0) & ~if_flush_i.
  - Push and pop in the same cycle leave count unchanged.
- Flush clears count and both queue pointers in the next cycle.
- Head outputs:
  - If count ≠ 0 and ~if_flush_i, if_parcel_valid_o = all-ones << head_pc[1 +: $clog2(XLEN/PARCEL_SIZE)]; otherwise it is 0.
  - if_parcel_error_o = head err & (count ≠ 0).
  - if_parcel_misaligned_o = head_pc[0] when HAS_RVC, otherwise |head_pc[1:0].
- Overflow cannot occur: credit gating guarantees that push while count=DEPTH never happens.

## Timing
- Reset state:
  - inflight, discard, count and both pointers are 0.
  - if_parcel_valid_o, if_parcel_error_o and if_ack_o are 0.
  - biu_stb_o stays 0 until rst_ni deasserts and the request conditions hold.
- Issue is combinational: if_ack_o follows biu_stb_ack_i in the same cycle.
- A response accepted in cycle N becomes visible at the queue head in cycle N+1. There is no bypass path.
- Pop in cycle N exposes the next entry in N+1.
- Throughput is one push and one pop per cycle; sustained when occ < DEPTH.
- A flush in cycle N:
  - Masks the outputs in cycle N.
  - Leaves the queue empty in cycle N+1.
  - Allows no issue in cycle N.
  - Drops exactly the responses to requests accepted before N+1.
- Reset asserted mid-transfer: all state clears asynchronously. Responses the BIU delivers after reset are not tracked, so the BIU must be reset together with this block.

## Test plan
- Fill (XLEN=32, DEPTH=4): if_req_i held, biu_stb_ack_i=1, no responses, if_parcel_rd_i=0 -> exactly 4 if_ack_o pulses, then biu_stb_o=0.
- Drain: return 4 responses at 0x100, 0x104, 0x108, 0x10C, then pulse if_parcel_rd_i -> head PCs appear in order, valid mask=2'b11, biu_stb_o re-asserts after the first pop.
- Flush with 3 in flight and 1 queued:
  - if_flush_i for 1 cycle -> discard=3 and the queue empties.
  - The next 3 responses are dropped.
  - The 4th response, to a post-flush request, appears with valid set.
- Flush coincident with a response: inflight=2, rsp in the flush cycle -> discard=1 and that response is not pushed.
- Error and misalignment: biu_err_i returned with adro=0x202, HAS_RVC=1 -> head err=1, misaligned=0, valid=2'b10. The same case with HAS_RVC=0 gives misaligned=1.
- Gating: dcflush_rdy_i=0 -> biu_stb_o=0 regardless of if_req_i.

Source files
------------

// File: rtl/riscv_noicache_pfq_if.sv
// BIU request/response channel between the no-icache fetch queue and the instruction BIU.
// master = fetch front end, slave = BIU.
interface riscv_noicache_pfq_if #(
    parameter int XLEN = 32,
    parameter int ALEN = XLEN
);
    logic            biu_stb;
    logic            biu_stb_ack;
    logic            biu_d_ack;
    logic [ALEN-1:0] biu_adri;
    logic [ALEN-1:0] biu_adro;
    logic [2:0]      biu_size;
    logic [2:0]      biu_type;
    logic            biu_lock;
    logic            biu_we;
    // Protection attributes: {cacheable, privileged, instruction}
    logic [2:0]      biu_prot;
    logic [XLEN-1:0] biu_d;
    logic [XLEN-1:0] biu_q;
    logic            biu_ack;
    logic            biu_err;

    modport master (
        output biu_stb, biu_adri, biu_size, biu_type, biu_lock, biu_we, biu_prot, biu_d,
        input  biu_stb_ack, biu_d_ack, biu_adro, biu_q, biu_ack, biu_err
    );

    modport slave (
        input  biu_stb, biu_adri, biu_size, biu_type, biu_lock, biu_we, biu_prot, biu_d,
        output biu_stb_ack, biu_d_ack, biu_adro, biu_q, biu_ack, biu_err
    );
endinterface

// File: rtl/riscv_noicache_pfq.sv
// Instruction-fetch front end without icache: credit-limited BIU requests feeding a
// DEPTH-entry prefetch queue, with stale responses discarded after a flush.
module riscv_noicache_pfq #(
    parameter int XLEN        = 32,
    parameter int ALEN        = XLEN,
    parameter int PARCEL_SIZE = 16,
    parameter int HAS_RVC     = 0,
    parameter int DEPTH       = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic [XLEN-1:0]               if_nxt_pc_i,
    input  logic                          if_req_i,
    output logic                          if_ack_o,
    input  logic [2:0]                    if_prot_i,
    input  logic                          if_flush_i,
    input  logic                          if_parcel_rd_i,
    output logic [XLEN-1:0]               if_parcel_pc_o,
    output logic [XLEN-1:0]               if_parcel_o,
    output logic [XLEN/PARCEL_SIZE-1:0]   if_parcel_valid_o,
    output logic                          if_parcel_misaligned_o,
    output logic                          if_parcel_error_o,
    input  logic                          dcflush_rdy_i,

    riscv_noicache_pfq_if.master          biu
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int NPAR = XLEN / PARCEL_SIZE;
    localparam int IW   = (NPAR > 1) ? $clog2(NPAR) : 1;
    localparam int AW   = $clog2(XLEN / 8);

    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [2:0] SIZE_DWORD  = 3'd3;
    localparam logic [2:0] TYPE_SINGLE = 3'd0;
    localparam logic [2:0] TYPE_INCR   = 3'd1;

    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] discard_reg,  discard_next;
    logic [CW-1:0] count_reg,    count_next;
    logic [PW-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg,   rd_ptr_next;

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] dat_mem [DEPTH];
    logic            err_mem [DEPTH];

    logic [CW:0]     occ;
    logic            stb, ack, rsp, push, pop, not_empty;
    logic [XLEN-1:0] head_pc;
    logic [IW-1:0]   head_idx;
    logic            unused_d_ack;

    assign unused_d_ack = biu.biu_d_ack;

    // Credits cover both in-flight requests and queued parcels, so a push never overflows.
    assign occ       = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign stb       = rst_ni & dcflush_rdy_i & ~if_flush_i & if_req_i & (occ < (CW+1)'(DEPTH));
    assign ack       = stb & biu.biu_stb_ack;
    assign rsp       = biu.biu_ack | biu.biu_err;
    assign push      = rsp & (discard_reg == '0) & ~if_flush_i;
    assign not_empty = (count_reg != '0);
    assign pop       = if_parcel_rd_i & not_empty & ~if_flush_i;

    assign if_ack_o      = ack;
    assign biu.biu_stb   = stb;
    assign biu.biu_adri  = if_nxt_pc_i[ALEN-1:0];
    assign biu.biu_size  = (XLEN == 64) ? SIZE_DWORD : SIZE_WORD;
    assign biu.biu_type  = (|if_nxt_pc_i[AW-1:0]) ? TYPE_SINGLE : TYPE_INCR;
    assign biu.biu_prot  = if_prot_i;
    assign biu.biu_lock  = 1'b0;
    assign biu.biu_we    = 1'b0;
    assign biu.biu_d     = '0;

    always_comb begin
        inflight_next = inflight_reg;
        if (ack && !rsp)
            inflight_next = inflight_reg + 1'b1;
        else if (!ack && rsp && inflight_reg != '0)
            inflight_next = inflight_reg - 1'b1;

        // On flush every request still outstanding is stale, except one answered right now.
        discard_next = discard_reg;
        if (if_flush_i)
            discard_next = (rsp && inflight_reg != '0) ? inflight_reg - 1'b1 : inflight_reg;
        else if (rsp && discard_reg != '0)
            discard_next = discard_reg - 1'b1;

        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (if_flush_i) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push && !pop)
                count_next = count_reg + 1'b1;
            else if (!push && pop)
                count_next = count_reg - 1'b1;
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_reg <= '0;
            discard_reg  <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            inflight_reg <= inflight_next;
            discard_reg  <= discard_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_reg]  <= XLEN'(biu.biu_adro);
            dat_mem[wr_ptr_reg] <= biu.biu_q;
            err_mem[wr_ptr_reg] <= biu.biu_err;
        end
    end

    assign head_pc  = pc_mem[rd_ptr_reg];
    assign head_idx = (NPAR > 1) ? head_pc[1 +: IW] : '0;

    assign if_parcel_pc_o    = head_pc;
    assign if_parcel_o       = dat_mem[rd_ptr_reg];
    assign if_parcel_valid_o = (not_empty && !if_flush_i) ? ({NPAR{1'b1}} << head_idx) : '0;
    assign if_parcel_error_o = err_mem[rd_ptr_reg] & not_empty;
    assign if_parcel_misaligned_o = (HAS_RVC != 0) ? head_pc[0] : |head_pc[1:0];
endmodule
